// File: rtl/alu_regfile.sv
// ---------------------------------------------------------------------------
// alu_regfile
//   Operand register file feeding the alu a/b inputs, with a per-register
//   busy scoreboard for results still in flight from multi-cycle producers.
//   r0 has no storage: it always reads as zero and is never busy.
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-high reset (clears data and busy bits)
//   ra1/ra2    read addresses (port 1 -> alu a, port 2 -> alu b)
//   rd1/rd2    combinational read data, with same-cycle write bypass
//   rd1_busy   ra1 has a pending write not resolved this cycle
//   rd2_busy   ra2 has a pending write not resolved this cycle
//   we/wa/wd   synchronous write port
//   set_busy   mark busy_addr as pending (multi-cycle op issued)
//   busy_addr  register to mark busy
//   any_busy   OR of all registered busy bits
// ---------------------------------------------------------------------------
module alu_regfile #(
    parameter int N    = 16,
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [N-1:0]  rd1,
    output logic [N-1:0]  rd2,
    output logic          rd1_busy,
    output logic          rd2_busy,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [N-1:0]  wd,
    input  logic          set_busy,
    input  logic [AW-1:0] busy_addr,
    output logic          any_busy
);

    // Storage exists only for r1..r(NREG-1).
    logic [N-1:0]      regs [1:NREG-1];
    logic [NREG-1:1]   busy;

    // Bypassed read: the writeback in progress this cycle is visible at once.
    function automatic logic [N-1:0] read_data(input logic [AW-1:0] ra,
                                               input logic [N-1:0]  stored);
        logic [N-1:0] v;
        v = '0;
        if (ra != '0) begin
            if (we && (wa == ra)) v = wd;
            else                  v = stored;
        end
        return v;
    endfunction

    // A writeback landing this cycle resolves the hazard, since the bypass
    // supplies the data.
    function automatic logic read_busy(input logic [AW-1:0] ra,
                                       input logic          stored);
        return (ra != '0) && stored && !(we && (wa == ra));
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            if (we && (wa != '0)) regs[wa] <= wd;
            for (int i = 1; i < NREG; i++) begin
                // Set takes priority over clear: a newly issued producer
                // supersedes the writeback of the previous one.
                if (set_busy && (busy_addr == AW'(i)))
                    busy[i] <= 1'b1;
                else if (we && (wa == AW'(i)))
                    busy[i] <= 1'b0;
            end
        end
    end

    logic [N-1:0] st1, st2;
    logic         sb1, sb2;

    // Index guards keep the r0 (no storage) address out of the arrays.
    always_comb begin
        st1 = '0;
        st2 = '0;
        sb1 = 1'b0;
        sb2 = 1'b0;
        if (ra1 != '0) begin
            st1 = regs[ra1];
            sb1 = busy[ra1];
        end
        if (ra2 != '0) begin
            st2 = regs[ra2];
            sb2 = busy[ra2];
        end
    end

    assign rd1      = read_data(ra1, st1);
    assign rd2      = read_data(ra2, st2);
    assign rd1_busy = read_busy(ra1, sb1);
    assign rd2_busy = read_busy(ra2, sb2);
    assign any_busy = |busy;

endmodule

// File: tb/tb_alu_regfile.sv
// Randomized + directed bench for alu_regfile against a behavioural model.
module tb_alu_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  ra1, ra2, wa, busy_addr;
    logic [15:0] rd1, rd2, wd;
    logic        rd1_busy, rd2_busy, we, set_busy, any_busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain arrays, updated from the architectural rules.
    logic [15:0] m_regs [8];
    bit          m_busy [8];

    always #5 clk = ~clk;

    alu_regfile #(.N(16), .NREG(8), .AW(3)) dut (
        .clk(clk), .rst(rst),
        .ra1(ra1), .ra2(ra2),
        .rd1(rd1), .rd2(rd2),
        .rd1_busy(rd1_busy), .rd2_busy(rd2_busy),
        .we(we), .wa(wa), .wd(wd),
        .set_busy(set_busy), .busy_addr(busy_addr),
        .any_busy(any_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_rd(input logic [2:0] ra);
        if (ra == 0) return 16'h0;
        if (we && wa == ra) return wd;
        return m_regs[ra];
    endfunction

    function automatic logic exp_busy(input logic [2:0] ra);
        if (ra == 0) return 1'b0;
        return m_busy[ra] && !(we && wa == ra);
    endfunction

    function automatic logic exp_any();
        logic a = 1'b0;
        for (int i = 0; i < 8; i++) a |= m_busy[i];
        return a;
    endfunction

    // Apply inputs away from the active edge, then compare all outputs.
    task automatic drive(input logic r, input logic w, input logic [2:0] a_wa,
                         input logic [15:0] a_wd, input logic sb, input logic [2:0] ba,
                         input logic [2:0] a1, input logic [2:0] a2);
        @(negedge clk);
        rst = r; we = w; wa = a_wa; wd = a_wd;
        set_busy = sb; busy_addr = ba; ra1 = a1; ra2 = a2;
        #1;
        check("rd1", 32'(rd1), 32'(exp_rd(ra1)));
        check("rd2", 32'(rd2), 32'(exp_rd(ra2)));
        check("rd1_busy", 32'(rd1_busy), 32'(exp_busy(ra1)));
        check("rd2_busy", 32'(rd2_busy), 32'(exp_busy(ra2)));
        check("any_busy", 32'(any_busy), 32'(exp_any()));
    endtask

    // Clock edge; the model follows the architectural update rules.
    task automatic edge_step();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_regs[i] = 16'h0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (we && wa != 0) begin
                m_regs[wa] = wd;
                m_busy[wa] = 1'b0;
            end
            if (set_busy && busy_addr != 0) m_busy[busy_addr] = 1'b1;
        end
    endtask

    task automatic cyc(input logic r, input logic w, input logic [2:0] a_wa,
                       input logic [15:0] a_wd, input logic sb, input logic [2:0] ba,
                       input logic [2:0] a1, input logic [2:0] a2);
        drive(r, w, a_wa, a_wd, sb, ba, a1, a2);
        edge_step();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = 16'h0;
            m_busy[i] = 1'b0;
        end
        rst = 1'b1; we = 0; wa = 0; wd = 0; set_busy = 0; busy_addr = 0; ra1 = 0; ra2 = 0;

        // 1. reset overrides a concurrent write
        cyc(1, 1, 3, 16'hFFFF, 0, 0, 3, 0);
        drive(0, 0, 0, 0, 0, 0, 3, 0);
        check("t1_rd1", 32'(rd1), 32'h0);
        check("t1_rd2", 32'(rd2), 32'h0);
        check("t1_busy", 32'({rd1_busy, rd2_busy, any_busy}), 32'h0);
        edge_step();

        // 2. write / bypass / hold / r0 write discarded
        drive(0, 1, 5, 16'h1234, 0, 0, 5, 0);
        check("t2_bypass", 32'(rd1), 32'h1234);
        edge_step();
        drive(0, 0, 0, 0, 0, 0, 5, 0);
        check("t2_hold", 32'(rd1), 32'h1234);
        edge_step();
        cyc(0, 1, 0, 16'hBEEF, 0, 0, 5, 0);
        drive(0, 0, 0, 0, 0, 0, 5, 0);
        check("t2_r0", 32'(rd2), 32'h0);
        edge_step();

        // 3. dual port same address, then bypass on one port only
        cyc(0, 1, 7, 16'h00A5, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 7, 7);
        check("t3_rd1", 32'(rd1), 32'h00A5);
        check("t3_rd2", 32'(rd2), 32'h00A5);
        edge_step();
        drive(0, 1, 2, 16'h8001, 0, 0, 2, 7);
        check("t3_byp1", 32'(rd1), 32'h8001);
        check("t3_rd2b", 32'(rd2), 32'h00A5);
        edge_step();

        // 4. scoreboard lifecycle
        cyc(0, 0, 0, 0, 1, 4, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 4, 0);
        check("t4_busy", 32'({rd1_busy, any_busy}), 32'h3);
        edge_step();
        drive(0, 1, 4, 16'h0042, 0, 0, 4, 0);
        check("t4_wb_busy", 32'(rd1_busy), 32'h0);
        check("t4_wb_data", 32'(rd1), 32'h0042);
        edge_step();
        drive(0, 0, 0, 0, 0, 0, 4, 0);
        check("t4_any", 32'(any_busy), 32'h0);
        edge_step();

        // 5. set and clear on the same register: set wins
        cyc(0, 0, 0, 0, 1, 6, 0, 0);
        cyc(0, 1, 6, 16'h0010, 1, 6, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 6, 0);
        check("t5_data", 32'(rd1), 32'h0010);
        check("t5_busy", 32'(rd1_busy), 32'h1);
        edge_step();
        cyc(0, 1, 6, 16'h0020, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 6, 0);
        check("t5_clr", 32'({rd1_busy, rd1}), {15'h0, 1'b0, 16'h0020});
        edge_step();

        // 6. reset mid-flight
        cyc(0, 0, 0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 3, 0, 0);
        cyc(0, 1, 3, 16'h5555, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 3);
        check("t6_any", 32'(any_busy), 32'h0);
        check("t6_rd", 32'({rd1, rd2}), 32'h0);
        check("t6_busy", 32'({rd1_busy, rd2_busy}), 32'h0);
        edge_step();

        // Randomized traffic, addresses and write/set densities biased to
        // produce frequent hazards, bypasses and set/clear collisions.
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] a = 3'($urandom_range(0, 7));
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 3) == 0) ? a : 3'($urandom_range(0, 7)),
                16'($urandom),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 3) == 0) ? a : 3'($urandom_range(0, 7)),
                ($urandom_range(0, 1) == 0) ? a : 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
